// File: rtl/picorv32_pcpi_arb.sv
// picorv32_pcpi_arb: registered PCPI dispatcher steering M-extension requests to a multiplier or divider.
// Optional perf counters are built only when PICORV32_PCPI_ARB_PERF_EN is defined.
module picorv32_pcpi_arb #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pcpi_valid,
  input  logic [31:0]      pcpi_insn,
  input  logic [31:0]      pcpi_rs1,
  input  logic [31:0]      pcpi_rs2,
  output logic             pcpi_wr,
  output logic [31:0]      pcpi_rd,
  output logic             pcpi_wait,
  output logic             pcpi_ready,
  output logic             mul_valid,
  output logic [31:0]      mul_insn,
  output logic [31:0]      mul_rs1,
  output logic [31:0]      mul_rs2,
  input  logic             mul_wr,
  input  logic [31:0]      mul_rd,
  input  logic             mul_ready,
  output logic             div_valid,
  output logic [31:0]      div_insn,
  output logic [31:0]      div_rs1,
  output logic [31:0]      div_rs2,
  input  logic             div_wr,
  input  logic [31:0]      div_rd,
  input  logic             div_ready,
  output logic             timeout_err,
  output logic [CNT_W-1:0] cnt_mul,
  output logic [CNT_W-1:0] cnt_div,
  output logic [CNT_W-1:0] cnt_stall
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_insn, r_rs1, r_rs2, r_rd;
  logic [15:0] r_cnt;
  logic        r_sel, r_wr, r_rearm, r_terr;
  logic        w_match, w_accept, w_sel_ready, w_done, w_tout;
  assign w_match     = pcpi_insn[6:0] == 7'b0110011 && pcpi_insn[31:25] == 7'b0000001;
  assign w_accept    = r_state == IDLE && pcpi_valid && w_match && r_rearm;
  assign w_sel_ready = r_sel ? div_ready : mul_ready;
  assign w_done      = r_state == BUSY && pcpi_valid && w_sel_ready;
  assign w_tout      = r_state == BUSY && pcpi_valid && !w_sel_ready && r_cnt == 16'(TIMEOUT - 1);
  assign mul_insn    = r_insn;
  assign mul_rs1     = r_rs1;
  assign mul_rs2     = r_rs2;
  assign div_insn    = r_insn;
  assign div_rs1     = r_rs1;
  assign div_rs2     = r_rs2;
  assign timeout_err = r_terr;
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  // next state and state-decoded handshake outputs; abort beats ready, ready beats timeout
  always_comb begin
    w_next     = r_state;
    mul_valid  = 1'b0;
    div_valid  = 1'b0;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;
    case (r_state)
      IDLE: w_next = w_accept ? BUSY : IDLE;
      BUSY: begin
        mul_valid = !r_sel;
        div_valid = r_sel;
        pcpi_wait = 1'b1;
        w_next    = !pcpi_valid ? IDLE : (w_sel_ready || w_tout) ? RESP : BUSY;
      end
      RESP: begin
        pcpi_ready = 1'b1;
        pcpi_wr    = r_wr;
        pcpi_rd    = r_rd;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // request capture, busy-cycle counter, response latch, sticky timeout and re-arm flag
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_insn  <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_sel   <= 1'b0;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_rd    <= '0;
      r_terr  <= 1'b0;
      r_rearm <= 1'b1;
    end else begin
      if (w_accept) begin
        r_insn <= pcpi_insn;
        r_rs1  <= pcpi_rs1;
        r_rs2  <= pcpi_rs2;
        r_sel  <= pcpi_insn[14];
      end
      r_cnt <= (r_state == BUSY && w_next == BUSY) ? r_cnt + 16'd1 : '0;
      if (w_done) begin
        r_wr <= r_sel ? div_wr : mul_wr;
        r_rd <= r_sel ? div_rd : mul_rd;
      end else if (w_tout) begin
        r_wr   <= 1'b0;
        r_rd   <= '0;
        r_terr <= 1'b1;
      end
      r_rearm <= !pcpi_valid ? 1'b1 : r_state == RESP ? 1'b0 : r_rearm;
    end
`ifdef PICORV32_PCPI_ARB_PERF_EN
  logic [CNT_W-1:0] r_cnt_mul, r_cnt_div, r_cnt_stall;
  // dispatch and stall counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_cnt_mul   <= '0;
      r_cnt_div   <= '0;
      r_cnt_stall <= '0;
    end else begin
      if (w_accept && !pcpi_insn[14]) r_cnt_mul <= r_cnt_mul + 1'b1;
      if (w_accept && pcpi_insn[14]) r_cnt_div <= r_cnt_div + 1'b1;
      if (r_state == BUSY) r_cnt_stall <= r_cnt_stall + 1'b1;
    end
  assign cnt_mul   = r_cnt_mul;
  assign cnt_div   = r_cnt_div;
  assign cnt_stall = r_cnt_stall;
`else
  assign cnt_mul   = '0;
  assign cnt_div   = '0;
  assign cnt_stall = '0;
`endif
endmodule
